// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero detector datapath: default
// operand/count widths and the normalizer state encoding.
package lzd_pkg;

  localparam int LZD_WIDTH = 8;
  localparam int LZD_CNT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/lzd_normalizer.sv
// Iterative normalizer: left-shifts an operand one bit per cycle by its
// (saturated) leading-zero count and hands the result off via valid/ready.
module lzd_normalizer
  import lzd_pkg::*;
#(
  parameter int WIDTH = LZD_WIDTH,
  parameter int CNT_W = LZD_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_lz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. out_valid/out_data are held stable until out_ready; in_ready may
  // depend on out_ready only while a result is being held (DONE).

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shift_q;
  logic             zero_q;

  logic             accept;
  logic             in_is_zero;
  logic [CNT_W-1:0] lz_sat;

  assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready;
  assign in_is_zero = (in_data == '0);
  assign lz_sat     = (in_lz > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      // Accept is only possible in IDLE or DONE, so loading here also covers
      // the back-to-back case where DONE hands off and reloads in one edge.
      data_q  <= in_data;
      cnt_q   <= lz_sat;
      shift_q <= in_is_zero ? CNT_W'(WIDTH) : lz_sat;
      zero_q  <= in_is_zero;
      state   <= (in_is_zero || (lz_sat == '0)) ? ST_DONE : ST_SHIFT;
    end else begin
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_SHIFT: begin
          data_q <= data_q << 1;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_DONE);
  assign out_data  = data_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;

endmodule
